// File: rtl/seq_alu_if.sv
// Handshake and result bus for seq_alu: operands/opcode in, registered result and flags out.
// The master modport belongs to the producer/consumer; the slave modport belongs to the ALU.
interface seq_alu_if #(
    parameter int WIDTH = 8
) ();
    logic             In_Valid;
    logic             In_Ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       ALU_Sel;
    logic             Out_Valid;
    logic             Out_Ready;
    logic [WIDTH-1:0] Result;
    logic             Zero;
    logic             Carry;
    logic             Overflow;
    logic             Negative;
    logic             Busy;

    modport master (
        output In_Valid, A, B, ALU_Sel, Out_Ready,
        input  In_Ready, Out_Valid, Result, Zero, Carry, Overflow, Negative, Busy
    );

    modport slave (
        input  In_Valid, A, B, ALU_Sel, Out_Ready,
        output In_Ready, Out_Valid, Result, Zero, Carry, Overflow, Negative, Busy
    );
endinterface

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith/shift ops and an optional WIDTH-cycle shift-add
// multiplier, with a valid/ready result stage that holds Result and flags until consumed.
module seq_alu #(
    parameter int WIDTH  = 8,
    parameter bit MUL_EN = 1'b1
) (
    input  logic     clk,
    input  logic     rst,
    seq_alu_if.slave bus
);
    localparam int MSB = WIDTH - 1;
    localparam int SW  = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic             accept;
    logic             is_mul_op;
    logic             load_alu;
    logic             mul_start;
    logic             mul_last;

    logic [WIDTH:0]   sum_full;
    logic [WIDTH:0]   diff_full;
    logic [WIDTH:0]   shl_full;
    logic [SW-1:0]    shamt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic             alu_ovf;

    logic [2*WIDTH-1:0] acc_reg;
    logic [2*WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0]   mplier_reg;
    logic [CW-1:0]      cnt_reg;
    logic [2*WIDTH-1:0] acc_sum;

    logic [WIDTH-1:0] result_reg;
    logic             zero_reg;
    logic             carry_reg;
    logic             ovf_reg;
    logic             neg_reg;

    assign accept    = bus.In_Valid && (state_reg == IDLE);
    assign is_mul_op = (bus.ALU_Sel == 3'b111) && MUL_EN;
    assign mul_start = accept && is_mul_op;
    assign mul_last  = (state_reg == MUL) && (cnt_reg == CW'(WIDTH - 1));

    // Single-cycle datapath; opcode 111 falls through to zero, which is the
    // required result when the multiplier is not built.
    always_comb begin
        sum_full  = {1'b0, bus.A} + {1'b0, bus.B};
        diff_full = {1'b0, bus.A} - {1'b0, bus.B};
        shamt     = bus.B[SW-1:0];
        shl_full  = {1'b0, bus.A} << shamt;
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (bus.ALU_Sel)
            3'b000: begin
                alu_res   = sum_full[MSB:0];
                alu_carry = sum_full[WIDTH];
                alu_ovf   = (bus.A[MSB] == bus.B[MSB]) && (sum_full[MSB] != bus.A[MSB]);
            end
            3'b001: begin
                alu_res   = diff_full[MSB:0];
                alu_carry = diff_full[WIDTH];
                alu_ovf   = (bus.A[MSB] != bus.B[MSB]) && (diff_full[MSB] != bus.A[MSB]);
            end
            3'b010: alu_res = bus.A & bus.B;
            3'b011: alu_res = bus.A | bus.B;
            3'b100: alu_res = ~bus.B;
            3'b101: alu_res = bus.A ^ bus.B;
            3'b110: begin
                // Bit WIDTH of the widened shift is the last bit pushed out (0 when shamt is 0).
                alu_res   = shl_full[MSB:0];
                alu_carry = shl_full[WIDTH];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        load_alu   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (is_mul_op) begin
                        state_next = MUL;
                    end else begin
                        load_alu   = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            MUL: begin
                if (mul_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.Out_Ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    generate
        if (MUL_EN) begin : g_mul
            // One multiplier bit per cycle: add the shifted multiplicand when the LSB is set.
            assign acc_sum = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    acc_reg    <= '0;
                    mcand_reg  <= '0;
                    mplier_reg <= '0;
                    cnt_reg    <= '0;
                end else if (mul_start) begin
                    acc_reg    <= '0;
                    mcand_reg  <= {{WIDTH{1'b0}}, bus.A};
                    mplier_reg <= bus.B;
                    cnt_reg    <= '0;
                end else if (state_reg == MUL) begin
                    acc_reg    <= acc_sum;
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    cnt_reg    <= cnt_reg + CW'(1);
                end
            end
        end else begin : g_no_mul
            assign acc_sum    = '0;
            assign acc_reg    = '0;
            assign mcand_reg  = '0;
            assign mplier_reg = '0;
            assign cnt_reg    = '0;
        end
    endgenerate

    // Result and flags change only when an operation completes, so they hold through DONE and IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_reg <= '0;
            zero_reg   <= 1'b0;
            carry_reg  <= 1'b0;
            ovf_reg    <= 1'b0;
            neg_reg    <= 1'b0;
        end else if (load_alu) begin
            result_reg <= alu_res;
            zero_reg   <= (alu_res == '0);
            carry_reg  <= alu_carry;
            ovf_reg    <= alu_ovf;
            neg_reg    <= alu_res[MSB];
        end else if (mul_last) begin
            result_reg <= acc_sum[MSB:0];
            zero_reg   <= (acc_sum[MSB:0] == '0);
            carry_reg  <= |acc_sum[2*WIDTH-1:WIDTH];
            ovf_reg    <= 1'b0;
            neg_reg    <= acc_sum[MSB];
        end
    end

    assign bus.In_Ready  = (state_reg == IDLE);
    assign bus.Out_Valid = (state_reg == DONE);
    assign bus.Busy      = (state_reg != IDLE);
    assign bus.Result    = result_reg;
    assign bus.Zero      = zero_reg;
    assign bus.Carry     = carry_reg;
    assign bus.Overflow  = ovf_reg;
    assign bus.Negative  = neg_reg;
endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (WIDTH=8): directed and random ops, backpressure and mid-multiply reset.
module tb_seq_alu;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seq_alu_if #(.WIDTH(W)) bus();

    seq_alu #(.WIDTH(W), .MUL_EN(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [11:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference model in plain integer arithmetic; returns {Result, Zero, Carry, Overflow, Negative}.
    function automatic logic [11:0] model(input int a, input int b, input int sel);
        int res = 0;
        int c   = 0;
        int v   = 0;
        int sa  = (a >= 128) ? a - 256 : a;
        int sb  = (b >= 128) ? b - 256 : b;
        int s;
        int sh;
        int full;
        case (sel)
            0: begin
                full = a + b;  res = full % 256;  c = (full > 255) ? 1 : 0;
                s = sa + sb;   v = (s > 127 || s < -128) ? 1 : 0;
            end
            1: begin
                full = a - b;  res = (full + 256) % 256;  c = (a < b) ? 1 : 0;
                s = sa - sb;   v = (s > 127 || s < -128) ? 1 : 0;
            end
            2: res = a & b;
            3: res = a | b;
            4: res = 255 - b;
            5: res = a ^ b;
            6: begin
                sh  = b % 8;
                res = (a << sh) % 256;
                c   = (sh == 0) ? 0 : ((a >> (8 - sh)) & 1);
            end
            default: begin
                full = a * b;  res = full % 256;  c = (full > 255) ? 1 : 0;
            end
        endcase
        return {8'(res), (res == 0), c[0], v[0], (res >= 128)};
    endfunction

    // Monitor: every valid cycle must match the head of the queue; pop on handshake.
    initial begin
        logic [11:0] act;
        forever begin
            @(negedge clk);
            if (bus.Out_Valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    act = {bus.Result, bus.Zero, bus.Carry, bus.Overflow, bus.Negative};
                    chk("result_flags", 32'(act), 32'(exp_q[0]));
                    if (bus.Out_Ready) begin
                        $display("txn result=%02h z=%0b c=%0b v=%0b n=%0b",
                                 bus.Result, bus.Zero, bus.Carry, bus.Overflow, bus.Negative);
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, keep In_Valid high with junk operands while busy, hold Out_Ready low for 'hold' cycles.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [2:0] sel, input int hold);
        int n = 0;
        int lat;
        int exp_lat;
        bit busy_bad = 1'b0;
        while (!bus.In_Ready && n < 50) begin
            cyc();
            n++;
        end
        if (!bus.In_Ready) begin
            chk("in_ready_timeout", 32'd0, 32'd1);
            return;
        end
        bus.A = a;  bus.B = b;  bus.ALU_Sel = sel;
        bus.In_Valid  = 1'b1;
        bus.Out_Ready = 1'b0;
        cyc();
        exp_q.push_back(model(int'(a), int'(b), int'(sel)));
        lat = 1;
        while (!bus.Out_Valid && lat < 40) begin
            if (!bus.Busy || bus.In_Ready) busy_bad = 1'b1;
            bus.A = 8'($urandom);  bus.B = 8'($urandom);  bus.ALU_Sel = 3'($urandom);
            cyc();
            lat++;
        end
        exp_lat = (sel == 3'd7) ? W + 1 : 1;
        chk("latency", 32'(lat), 32'(exp_lat));
        if (sel == 3'd7) chk("mul_busy_not_ready", 32'(busy_bad), 32'd0);
        busy_bad = 1'b0;
        repeat (hold) begin
            bus.A = 8'($urandom);  bus.B = 8'($urandom);  bus.ALU_Sel = 3'($urandom);
            cyc();
            if (bus.In_Ready || !bus.Out_Valid) busy_bad = 1'b1;
        end
        if (hold > 0) chk("held_not_ready", 32'(busy_bad), 32'd0);
        bus.In_Valid  = 1'b0;
        bus.Out_Ready = 1'b1;
        cyc();
        bus.Out_Ready = 1'b0;
        chk("idle_after_ready", 32'({bus.Out_Valid, bus.In_Ready, bus.Busy}), 32'b010);
    endtask

    initial begin
        int  n;
        bit  seen;
        bus.In_Valid = 1'b0;  bus.A = '0;  bus.B = '0;  bus.ALU_Sel = '0;  bus.Out_Ready = 1'b0;
        #2;
        chk("reset_outputs", 32'({bus.Result, bus.Zero, bus.Carry, bus.Overflow, bus.Negative,
                                 bus.Out_Valid, bus.Busy}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc();
        chk("in_ready_after_reset", 32'(bus.In_Ready), 32'd1);

        issue(8'hFF, 8'h01, 3'd0, 0);
        issue(8'h32, 8'h0F, 3'd1, 1);
        issue(8'h0A, 8'h14, 3'd1, 0);
        issue(8'h80, 8'h01, 3'd1, 2);
        issue(8'h0F, 8'h11, 3'd7, 0);
        issue(8'h10, 8'h10, 3'd7, 1);
        issue(8'h81, 8'h01, 3'd6, 0);
        issue(8'h81, 8'h08, 3'd6, 0);
        for (int i = 0; i < 40; i++) begin
            issue(8'($urandom), 8'($urandom), 3'($urandom), int'($urandom_range(0, 3)));
        end

        // Backpressure with new operands presented throughout; leaves Result=08 behind.
        issue(8'h05, 8'h03, 3'd0, 5);

        // Reset three cycles into a multiply.
        bus.A = 8'h0F;  bus.B = 8'h11;  bus.ALU_Sel = 3'd7;  bus.In_Valid = 1'b1;
        cyc();
        bus.In_Valid = 1'b0;
        repeat (3) cyc();
        #2 rst = 1'b1;
        #1;
        chk("reset_mid_mul_outputs", 32'({bus.Result, bus.Zero, bus.Carry, bus.Overflow, bus.Negative,
                                         bus.Out_Valid, bus.Busy}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc();
        chk("in_ready_after_mid_reset", 32'(bus.In_Ready), 32'd1);
        seen = 1'b0;
        repeat (12) begin
            if (bus.Out_Valid) seen = 1'b1;
            cyc();
        end
        chk("no_out_valid_after_reset", 32'(seen), 32'd0);

        issue(8'h03, 8'h04, 3'd7, 0);

        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            cyc();
            n++;
        end
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
